imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, pipelined RISC-V immediate generator. It replaces the combinational sign extender in the decode path.
//  - Takes a raw 32-bit instruction and derives the format from opcode[6:2].
//  - Builds the I/S/B/U/J immediate and sign- or zero-extends it to XLEN.
//  - Output flows through a 2-stage elastic valid/ready pipeline with flush.
//  - Counts unsupported opcodes for debug.
// PARAMETERS
//  XLEN      32  output immediate width; legal values 32 or 64.
//  CNT_W     8   width of the saturating illegal-opcode counter.
// PORTS
//  clk        in   1      single clock; all state updates on rising edge.
//  rst        in   1      synchronous, active-high reset.
//  flush      in   1      drop all in-flight entries (branch mispredict / trap).
//  in_valid   in   1      instr/zext_req valid this cycle.
//  in_ready   out  1      pipeline accepts input this cycle.
//  instr      in   32     raw instruction word.
//  zext_req   in   1      1 = zero-extend I-format immediate; ignored for other formats.
//  out_valid  out  1      imm/fmt/illegal valid.
//  out_ready  in   1      consumer accepts output this cycle.
//  imm        out  XLEN   extended immediate.
//  fmt        out  3      0=NONE 1=I 2=S 3=B 4=U 5=J.
//  illegal    out  1      opcode not in the supported table (imm=0, fmt=NONE).
//  ill_cnt    out  CNT_W  saturating count of illegal entries delivered at output.
// BEHAVIOUR
//  Opcode table (opcode[6:2]):
//   - I: 00000 LOAD, 00100 OP-IMM, 11001 JALR.
//   - S: 01000.  B: 11000.
//   - U: 01101 LUI, 00101 AUIPC.  J: 11011.
//   - Any other value sets illegal=1.
//  Bits [1:0] are not checked.
//  Immediate construction:
//   - I: instr[31:20].
//   - S: {instr[31:25],instr[11:7]}.
//   - B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
//   - U: {instr[31:12],12'b0}.
//   - J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
//  Extension:
//   - Every format sign-extends from its top bit (instr[31]) to XLEN.
//   - Exception: I with zext_req=1 zero-extends.
//   - U also sign-extends from bit 31 to XLEN (RV64 semantics).
//  Pipeline:
//   - Stage S1 registers instr, zext_req and decoded fmt/illegal.
//   - Stage S2 registers the extended imm and drives all outputs directly from flops.
//   - Latency is exactly 2 cycles from input handshake to out_valid when out_ready stays high.
//   - Throughput is 1 per cycle.
//  Handshake:
//   - An input transfer happens when in_valid & in_ready.
//   - An output transfer happens when out_valid & out_ready.
//   - S2 loads when !s2_valid | out_ready.
//   - S1 loads when !s1_valid | S2 loads.
//   - in_ready equals the S1 load condition; it is combinational from out_ready, with no combinational path from in_valid.
//   - While out_valid=1 & out_ready=0, imm/fmt/illegal hold stable.
//  Flush:
//   - s1_valid and s2_valid clear at the next edge.
//   - An input presented in the flush cycle is dropped; in_ready may be 1 in that cycle.
//   - Data flops need not clear.
//   - ill_cnt is not affected.
//  ill_cnt:
//   - Increments when an output transfer carries illegal=1.
//   - Saturates at 2^CNT_W-1.
//   - Cleared only by rst.
//  Reset (synchronous):
//   - s1_valid=0, out_valid=0, imm=0, fmt=0, illegal=0, ill_cnt=0.
//   - in_ready=1 in the first cycle after reset deasserts.
//   - rst overrides flush and any handshake in the same cycle.
//   - rst asserted mid-stream discards all in-flight entries.
// TESTING
//  1. XLEN=64: ADDI instr=32'hFFF00093, zext_req=0 -> after 2 cycles imm=64'hFFFF_FFFF_FFFF_FFFF, fmt=1.
//     Same instr with zext_req=1 -> imm=64'h0000_0000_0000_0FFF.
//  2. XLEN=32 back-to-back, out_ready=1:
//     - BEQ 32'hFE000EE3 -> imm=32'hFFFF_FFFC, fmt=3.
//     - JAL 32'h0080006F -> imm=32'h0000_0008, fmt=5.
//     - LUI 32'h123450B7 -> imm=32'h1234_5000, fmt=4.
//     Outputs appear on consecutive cycles with no bubbles.
//  3. Backpressure: hold out_ready=0 for 5 cycles with 3 inputs offered.
//     -> 2 accepted, then in_ready=0 and outputs stable.
//     Release out_ready -> all entries delivered in order, none lost or duplicated.
//  4. Flush with both stages full and in_valid=1 -> next cycle out_valid=0.
//     The flushed entries and the flush-cycle input never appear at the output.
//  5. Illegal opcode 32'h0000007F at CNT_W=2, sent 5 times -> each output illegal=1, imm=0, fmt=0.
//     ill_cnt goes 1,2,3,3,3.
//  6. Assert rst for 1 cycle mid-stream -> out_valid=0, ill_cnt=0 next cycle; in_ready=1 once rst deasserts.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: opcode decode in S1, extended immediate in S2,
// elastic valid/ready handshake with flush and a saturating illegal-opcode counter.
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic             zext_req,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm,
   output logic [2:0]       fmt,
   output logic             illegal,
   output logic [CNT_W-1:0] ill_cnt
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;

   // Operand bits [1:0] play no part in decode or immediate construction
   logic unused_instr_lsbs;
   assign unused_instr_lsbs = ^instr[1:0];

   logic        s1_valid;
   logic [31:7] s1_instr;
   logic        s1_zext;
   logic [2:0]  s1_fmt;
   logic        s1_illegal;

   logic        s2_load;
   logic        s1_load;
   logic [2:0]  dec_fmt;
   logic        dec_illegal;
   logic [31:0] raw_imm;
   logic [XLEN-1:0] ext_imm;

   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   // Format decode from opcode[6:2]
   always_comb begin
      dec_fmt     = FMT_NONE;
      dec_illegal = 1'b0;
      case (instr[6:2])
         5'b00000, 5'b00100, 5'b11001: dec_fmt = FMT_I;
         5'b01000:                     dec_fmt = FMT_S;
         5'b11000:                     dec_fmt = FMT_B;
         5'b01101, 5'b00101:           dec_fmt = FMT_U;
         5'b11011:                     dec_fmt = FMT_J;
         default:                      dec_illegal = 1'b1;
      endcase
   end

   // 32-bit immediate already extended from bit 31; zero-extended I leaves bit 31 clear,
   // so widening to XLEN is always a plain sign extension of this value.
   always_comb begin
      raw_imm = 32'd0;
      case (s1_fmt)
         FMT_I: raw_imm = s1_zext ? {20'd0, s1_instr[31:20]}
                                  : {{20{s1_instr[31]}}, s1_instr[31:20]};
         FMT_S: raw_imm = {{20{s1_instr[31]}}, s1_instr[31:25], s1_instr[11:7]};
         FMT_B: raw_imm = {{19{s1_instr[31]}}, s1_instr[31], s1_instr[7],
                           s1_instr[30:25], s1_instr[11:8], 1'b0};
         FMT_U: raw_imm = {s1_instr[31:12], 12'd0};
         FMT_J: raw_imm = {{11{s1_instr[31]}}, s1_instr[31], s1_instr[19:12],
                           s1_instr[20], s1_instr[30:21], 1'b0};
         default: raw_imm = 32'd0;
      endcase
   end

   assign ext_imm = XLEN'($signed(raw_imm));

   // Stage 1 valid
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
      end
   end

   // Stage 1 payload; only meaningful while s1_valid
   always_ff @(posedge clk) begin
      if (s1_load && in_valid) begin
         s1_instr   <= instr[31:7];
         s1_zext    <= zext_req;
         s1_fmt     <= dec_fmt;
         s1_illegal <= dec_illegal;
      end
   end

   // Stage 2: outputs come straight from these flops and hold while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         imm       <= '0;
         fmt       <= FMT_NONE;
         illegal   <= 1'b0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (s2_load) begin
            out_valid <= s1_valid;
         end
         if (s2_load && s1_valid && !flush) begin
            imm     <= ext_imm;
            fmt     <= s1_fmt;
            illegal <= s1_illegal;
         end
      end
   end

   // Illegal entries counted on delivery, saturating
   always_ff @(posedge clk) begin
      if (rst) begin
         ill_cnt <= '0;
      end else if (out_valid && out_ready && illegal && (ill_cnt != {CNT_W{1'b1}})) begin
         ill_cnt <= ill_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=64/CNT_W=2 and XLEN=32/CNT_W=8 instances
// driven in lockstep from directed vectors with hand-computed immediates.
module tb_imm_gen_pipe;

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic        zext;
      exp_t        e;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        zext_req = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] instr = 32'd0;

   logic        in_ready64, out_valid64, illegal64;
   logic [63:0] imm64;
   logic [2:0]  fmt64;
   logic [1:0]  ill_cnt64;
   logic        in_ready32, out_valid32, illegal32;
   logic [31:0] imm32;
   logic [2:0]  fmt32;
   logic [7:0]  ill_cnt32;

   exp_t cur;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   xfers = 0;
   int   model_cnt64 = 0;
   int   model_cnt32 = 0;

   imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .instr(instr), .zext_req(zext_req), .out_valid(out_valid64), .out_ready(out_ready),
      .imm(imm64), .fmt(fmt64), .illegal(illegal64), .ill_cnt(ill_cnt64));

   imm_gen_pipe #(.XLEN(32), .CNT_W(8)) u32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
      .instr(instr), .zext_req(zext_req), .out_valid(out_valid32), .out_ready(out_ready),
      .imm(imm32), .fmt(fmt32), .illegal(illegal32), .ill_cnt(ill_cnt32));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor/scoreboard: sampled on the falling edge, ahead of the edge that acts on it
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
         model_cnt64 = 0;
         model_cnt32 = 0;
      end else begin
         if (out_valid64 && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got imm 0x%0h fmt %0d, required no output at %0t",
                        imm64, fmt64, $time);
            end else begin
               e = q.pop_front();
               chk("imm64", imm64, e.imm);
               chk("fmt64", 64'(fmt64), 64'(e.fmt));
               chk("illegal64", 64'(illegal64), 64'(e.ill));
               chk("out_valid32", 64'(out_valid32), 64'd1);
               chk("imm32", 64'(imm32), 64'(e.imm[31:0]));
               chk("fmt32", 64'(fmt32), 64'(e.fmt));
               chk("illegal32", 64'(illegal32), 64'(e.ill));
               chk("ill_cnt64", 64'(ill_cnt64), 64'(model_cnt64));
               chk("ill_cnt32", 64'(ill_cnt32), 64'(model_cnt32));
               xfers++;
               if (e.ill) begin
                  if (model_cnt64 < 3)   model_cnt64++;
                  if (model_cnt32 < 255) model_cnt32++;
               end
            end
         end else if (out_valid64 && q.size() > 0) begin
            chk("stall_imm64", imm64, q[0].imm);
            chk("stall_fmt64", 64'(fmt64), 64'(q[0].fmt));
            chk("stall_imm32", 64'(imm32), 64'(q[0].imm[31:0]));
         end
         if (flush) begin
            q.delete();
         end else if (in_valid && in_ready64) begin
            q.push_back(cur);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] i, input logic z, input logic [63:0] ei,
                       input logic [2:0] ef, input logic el);
      logic acc;
      logic done;
      instr    = i;
      zext_req = z;
      cur      = '{imm: ei, fmt: ef, ill: el};
      in_valid = 1'b1;
      done     = 1'b0;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         acc = in_ready64;
         @(posedge clk);
         #1;
         done = acc;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: instr 0x%0h not accepted within 50 cycles", i);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 50 && q.size() != 0; k++) cyc(1);
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_t bp[3];
      int    idx;
      int    x0;
      logic  acc;

      // Reset state
      cyc(2);
      rst = 1'b0;
      chk("rst_out_valid", 64'(out_valid64), 64'd0);
      chk("rst_imm", imm64, 64'd0);
      chk("rst_fmt", 64'(fmt64), 64'd0);
      chk("rst_illegal", 64'(illegal64), 64'd0);
      chk("rst_ill_cnt", 64'(ill_cnt64), 64'd0);
      chk("rst_in_ready", 64'(in_ready64), 64'd1);

      // Latency of exactly two cycles
      out_ready = 1'b1;
      send(32'hFFF00093, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
      in_valid = 1'b0;
      chk("lat_cycle1_out_valid", 64'(out_valid64), 64'd0);
      cyc(1);
      chk("lat_cycle2_out_valid", 64'(out_valid64), 64'd1);
      send(32'hFFF00093, 1'b1, 64'h0000_0000_0000_0FFF, 3'd1, 1'b0);
      in_valid = 1'b0;
      drain();

      // Back-to-back stream covering every format and extension case
      x0 = xfers;
      send(32'hFE000EE3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
      send(32'h0080006F, 1'b0, 64'h0000_0000_0000_0008, 3'd5, 1'b0);
      send(32'h123450B7, 1'b0, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
      send(32'h800000B7, 1'b0, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
      send(32'hFE112E23, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
      send(32'hFE112E23, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
      send(32'h80000067, 1'b0, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0);
      send(32'h80000067, 1'b1, 64'h0000_0000_0000_0800, 3'd1, 1'b0);
      send(32'h00001097, 1'b0, 64'h0000_0000_0000_1000, 3'd4, 1'b0);
      send(32'h00402083, 1'b0, 64'h0000_0000_0000_0004, 3'd1, 1'b0);
      send(32'hFFF00090, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
      chk("burst_xfers_mid", 64'(xfers - x0), 64'd9);
      in_valid = 1'b0;
      cyc(2);
      chk("burst_xfers_end", 64'(xfers - x0), 64'd11);
      drain();

      // Backpressure: three offered over five stalled cycles
      bp[0] = '{instr: 32'h00402083, zext: 1'b0, e: '{imm: 64'h4, fmt: 3'd1, ill: 1'b0}};
      bp[1] = '{instr: 32'hFE000EE3, zext: 1'b0, e: '{imm: 64'hFFFF_FFFF_FFFF_FFFC, fmt: 3'd3, ill: 1'b0}};
      bp[2] = '{instr: 32'h0080006F, zext: 1'b0, e: '{imm: 64'h8, fmt: 3'd5, ill: 1'b0}};
      x0 = xfers;
      out_ready = 1'b0;
      idx = 0;
      for (int k = 0; k < 5; k++) begin
         instr    = bp[idx].instr;
         zext_req = bp[idx].zext;
         cur      = bp[idx].e;
         in_valid = 1'b1;
         @(negedge clk);
         acc = in_ready64;
         cyc(1);
         if (acc && idx < 2) idx++;
      end
      chk("bp_accepted", 64'(idx), 64'd2);
      chk("bp_in_ready", 64'(in_ready64), 64'd0);
      chk("bp_in_ready32", 64'(in_ready32), 64'd0);
      chk("bp_out_valid", 64'(out_valid64), 64'd1);
      out_ready = 1'b1;
      send(bp[2].instr, bp[2].zext, bp[2].e.imm, bp[2].e.fmt, bp[2].e.ill);
      in_valid = 1'b0;
      drain();
      chk("bp_delivered", 64'(xfers - x0), 64'd3);

      // Flush with both stages full and a new input offered
      out_ready = 1'b0;
      send(32'h123450B7, 1'b0, 64'h1234_5000, 3'd4, 1'b0);
      send(32'h0000007F, 1'b0, 64'd0, 3'd0, 1'b1);
      instr = 32'h0080006F;
      cur   = '{imm: 64'h8, fmt: 3'd5, ill: 1'b0};
      flush = 1'b1;
      cyc(1);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid64), 64'd0);
      chk("flush_out_valid32", 64'(out_valid32), 64'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         chk("flush_stays_empty", 64'(out_valid64), 64'd0);
      end

      // Flush on an empty pipeline: the flush-cycle input is dropped even though accepted
      in_valid = 1'b1;
      flush    = 1'b1;
      cyc(1);
      flush    = 1'b0;
      in_valid = 1'b0;
      cyc(2);
      chk("flush_drop_input", 64'(out_valid64), 64'd0);
      chk("flush_keeps_cnt", 64'(ill_cnt64), 64'd0);

      // Illegal opcode five times: counter saturates at 3 in the CNT_W=2 instance
      send(32'h0000007F, 1'b0, 64'd0, 3'd0, 1'b1);
      send(32'h0000007F, 1'b1, 64'd0, 3'd0, 1'b1);
      send(32'hFFFFFFF3, 1'b0, 64'd0, 3'd0, 1'b1);
      send(32'h0000007F, 1'b0, 64'd0, 3'd0, 1'b1);
      send(32'h0000007F, 1'b0, 64'd0, 3'd0, 1'b1);
      in_valid = 1'b0;
      drain();
      cyc(1);
      chk("ill_cnt64_sat", 64'(ill_cnt64), 64'd3);
      chk("ill_cnt32_count", 64'(ill_cnt32), 64'd5);

      // Reset mid-stream
      send(32'h123450B7, 1'b0, 64'h1234_5000, 3'd4, 1'b0);
      send(32'h0000007F, 1'b0, 64'd0, 3'd0, 1'b1);
      send(32'h0080006F, 1'b0, 64'h8, 3'd5, 1'b0);
      instr = 32'hFFF00093;
      cur   = '{imm: 64'hFFFF_FFFF_FFFF_FFFF, fmt: 3'd1, ill: 1'b0};
      rst   = 1'b1;
      cyc(1);
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("mid_rst_out_valid", 64'(out_valid64), 64'd0);
      chk("mid_rst_ill_cnt64", 64'(ill_cnt64), 64'd0);
      chk("mid_rst_ill_cnt32", 64'(ill_cnt32), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready64), 64'd1);
      chk("mid_rst_imm", imm64, 64'd0);
      cyc(3);
      chk("mid_rst_no_output", 64'(out_valid64), 64'd0);
      send(32'h00001097, 1'b0, 64'h1000, 3'd4, 1'b0);
      in_valid = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
